// File: rtl/lpif_pack_pkg.sv
// Shared types for the LPIF downstream lane packer: lane geometry, FSM states
// and the per-flit bundle carried through the hold and output registers.
package lpif_pack_pkg;

  localparam int LANE_W    = 64;
  localparam int NUM_LANES = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } pack_state_e;

  typedef struct packed {
    logic [LANE_W-1:0] data;
    logic              dvalid;
    logic [1:0]        protid;
    logic [3:0]        crc;
    logic              crc_valid;
  } flit_t;

endpackage

// File: rtl/lpif_pack_flush_timer.sv
// Counts idle cycles while a lone flit waits for a partner; expire_o marks the
// last cycle it may still be paired before it has to be flushed.
module lpif_pack_flush_timer #(
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic clk_wr,
  input  logic rst_wr,
  input  logic start_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int TW = (FLUSH_TIMEOUT < 1) ? 1 : $clog2(FLUSH_TIMEOUT + 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // With pairing disabled there is never a held flit, so never expire.
  assign expire_o = (FLUSH_TIMEOUT != 0) && (cnt_q == TW'(FLUSH_TIMEOUT - 1));

endmodule

// File: rtl/lpif_dstrm_lane_packer.sv
// Pairs consecutive single-lane LPIF flits onto the two-lane dstrm_* bus of the
// master top; a lone flit is flushed on lane 0 after a timeout or on link drop.
module lpif_dstrm_lane_packer
  import lpif_pack_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 8,
  parameter int CNT_W         = 16
) (
  input  logic                          clk_wr,
  input  logic                          rst_wr,
  input  logic                          link_online,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANE_W-1:0]             in_data,
  input  logic                          in_dvalid,
  input  logic [1:0]                    in_protid,
  input  logic [3:0]                    in_crc,
  input  logic                          in_crc_valid,
  input  logic [3:0]                    in_state,
  output logic [7:0]                    dstrm_state,
  output logic [3:0]                    dstrm_protid,
  output logic [NUM_LANES*LANE_W-1:0]   dstrm_data,
  output logic [NUM_LANES-1:0]          dstrm_dvalid,
  output logic [7:0]                    dstrm_crc,
  output logic [NUM_LANES-1:0]          dstrm_crc_valid,
  output logic [NUM_LANES-1:0]          dstrm_valid,
  output logic [31:0]                   pack_debug_status
);

  pack_state_e          state_q, state_d;
  flit_t                hold_q, hold_d;
  flit_t                inFlit;
  flit_t                lane0_q, lane0_d, lane1_q, lane1_d;
  logic [NUM_LANES-1:0] valid_q, valid_d;
  logic [7:0]           laneState_q;
  logic [CNT_W-1:0]     pairCnt_q, flushCnt_q;
  logic                 accept, pairInc, flushInc, expire;

  assign in_ready = link_online;
  assign accept   = in_valid & link_online;

  assign inFlit = '{data:      in_data,
                    dvalid:    in_dvalid,
                    protid:    in_protid,
                    crc:       in_crc,
                    crc_valid: in_crc_valid};

  lpif_pack_flush_timer #(
    .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
  ) u_flush_timer (
    .clk_wr   (clk_wr),
    .rst_wr   (rst_wr),
    .start_i  (state_q == HALF),
    .clear_i  (state_q == EMPTY),
    .expire_o (expire)
  );

  // Unused lanes stay all-zero, so the output register never needs extra gating.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    lane0_d  = '0;
    lane1_d  = '0;
    valid_d  = '0;
    pairInc  = 1'b0;
    flushInc = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          if (FLUSH_TIMEOUT == 0) begin
            lane0_d = inFlit;
            valid_d = 2'b01;
          end else begin
            hold_d  = inFlit;
            state_d = HALF;
          end
        end
      end
      HALF: begin
        if (accept) begin
          lane0_d = hold_q;
          lane1_d = inFlit;
          valid_d = 2'b11;
          pairInc = 1'b1;
          state_d = EMPTY;
        end else if (!link_online || expire) begin
          lane0_d  = hold_q;
          valid_d  = 2'b01;
          flushInc = 1'b1;
          state_d  = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      state_q     <= EMPTY;
      hold_q      <= '0;
      lane0_q     <= '0;
      lane1_q     <= '0;
      valid_q     <= '0;
      laneState_q <= '0;
      pairCnt_q   <= '0;
      flushCnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      lane0_q     <= lane0_d;
      lane1_q     <= lane1_d;
      valid_q     <= valid_d;
      laneState_q <= {in_state, in_state};
      if (pairInc && (pairCnt_q != '1)) begin
        pairCnt_q <= pairCnt_q + CNT_W'(1);
      end
      if (flushInc && (flushCnt_q != '1)) begin
        flushCnt_q <= flushCnt_q + CNT_W'(1);
      end
    end
  end

  assign dstrm_state       = laneState_q;
  assign dstrm_protid      = {lane1_q.protid, lane0_q.protid};
  assign dstrm_data        = {lane1_q.data, lane0_q.data};
  assign dstrm_dvalid      = valid_q & {lane1_q.dvalid, lane0_q.dvalid};
  assign dstrm_crc         = {lane1_q.crc, lane0_q.crc};
  assign dstrm_crc_valid   = valid_q & {lane1_q.crc_valid, lane0_q.crc_valid};
  assign dstrm_valid       = valid_q;
  assign pack_debug_status = {16'(flushCnt_q), 16'(pairCnt_q)};

endmodule

// File: tb/tb_lpif_dstrm_lane_packer.sv
// Directed bench for the lane packer: pairing, timeout flush, collision, link
// drop, field gating, state passthrough and async reset, plus a no-pairing instance.
module tb_lpif_dstrm_lane_packer;

  logic         clk_wr = 1'b0;
  logic         rst_wr;
  logic         link_online;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_data;
  logic         in_dvalid;
  logic [1:0]   in_protid;
  logic [3:0]   in_crc;
  logic         in_crc_valid;
  logic [3:0]   in_state;
  logic [7:0]   dstrm_state;
  logic [3:0]   dstrm_protid;
  logic [127:0] dstrm_data;
  logic [1:0]   dstrm_dvalid;
  logic [7:0]   dstrm_crc;
  logic [1:0]   dstrm_crc_valid;
  logic [1:0]   dstrm_valid;
  logic [31:0]  pack_debug_status;

  logic         d0InReady;
  logic [7:0]   d0State;
  logic [3:0]   d0Protid;
  logic [127:0] d0Data;
  logic [1:0]   d0Dvalid;
  logic [7:0]   d0Crc;
  logic [1:0]   d0CrcValid;
  logic [1:0]   d0Valid;
  logic [31:0]  d0Status;

  int totalChecks = 0;
  int badChecks   = 0;
  int pairExp     = 0;
  int flushExp    = 0;

  localparam logic [63:0] DATA_A = 64'h1111_1111_1111_1111;
  localparam logic [63:0] DATA_B = 64'h2222_2222_2222_2222;
  localparam logic [63:0] DATA_X = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] DATA_Y = 64'h89AB_CDEF_FEDC_BA98;

  always #5 clk_wr = ~clk_wr;

  lpif_dstrm_lane_packer #(.FLUSH_TIMEOUT(8), .CNT_W(16)) dut (
    .clk_wr            (clk_wr),
    .rst_wr            (rst_wr),
    .link_online       (link_online),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_dvalid         (in_dvalid),
    .in_protid         (in_protid),
    .in_crc            (in_crc),
    .in_crc_valid      (in_crc_valid),
    .in_state          (in_state),
    .dstrm_state       (dstrm_state),
    .dstrm_protid      (dstrm_protid),
    .dstrm_data        (dstrm_data),
    .dstrm_dvalid      (dstrm_dvalid),
    .dstrm_crc         (dstrm_crc),
    .dstrm_crc_valid   (dstrm_crc_valid),
    .dstrm_valid       (dstrm_valid),
    .pack_debug_status (pack_debug_status)
  );

  // Pairing disabled: every accepted flit leaves alone on lane 0 next cycle.
  lpif_dstrm_lane_packer #(.FLUSH_TIMEOUT(0), .CNT_W(16)) dut0 (
    .clk_wr            (clk_wr),
    .rst_wr            (rst_wr),
    .link_online       (link_online),
    .in_valid          (in_valid),
    .in_ready          (d0InReady),
    .in_data           (in_data),
    .in_dvalid         (in_dvalid),
    .in_protid         (in_protid),
    .in_crc            (in_crc),
    .in_crc_valid      (in_crc_valid),
    .in_state          (in_state),
    .dstrm_state       (d0State),
    .dstrm_protid      (d0Protid),
    .dstrm_data        (d0Data),
    .dstrm_dvalid      (d0Dvalid),
    .dstrm_crc         (d0Crc),
    .dstrm_crc_valid   (d0CrcValid),
    .dstrm_valid       (d0Valid),
    .pack_debug_status (d0Status)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [1:0] pid,
                               input logic dv, input logic [3:0] crc, input logic crcv);
    in_valid     = v;
    in_data      = d;
    in_protid    = pid;
    in_dvalid    = dv;
    in_crc       = crc;
    in_crc_valid = crcv;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 64'h0, 2'd0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk_wr);
  endtask

  task automatic checkStatus(input string tag);
    checkOutput(tag, {96'h0, pack_debug_status}, {96'h0, 16'(flushExp), 16'(pairExp)});
  endtask

  initial begin
    int cnt;
    logic [1:0] seen;

    rst_wr      = 1'b1;
    link_online = 1'b0;
    in_state    = 4'h0;
    idle();
    tick();
    tick();
    checkOutput("reset_valid", {126'h0, dstrm_valid}, 128'h0);
    checkOutput("reset_data", dstrm_data, 128'h0);
    checkStatus("reset_status");
    checkOutput("ready_offline", {127'h0, in_ready}, 128'h0);
    rst_wr      = 1'b0;
    link_online = 1'b1;
    #1;
    checkOutput("ready_online", {127'h0, in_ready}, 128'h1);
    tick();

    $display("[TB] pairing");
    applyStimulus(1'b1, DATA_A, 2'd1, 1'b1, 4'h3, 1'b1);
    tick();
    checkOutput("pair_wait_valid", {126'h0, dstrm_valid}, 128'h0);
    checkOutput("nopair_a_valid", {126'h0, d0Valid}, 128'h1);
    checkOutput("nopair_a_data", d0Data, {64'h0, DATA_A});
    applyStimulus(1'b1, DATA_B, 2'd2, 1'b1, 4'h4, 1'b1);
    tick();
    idle();
    pairExp++;
    checkOutput("pair_valid", {126'h0, dstrm_valid}, 128'h3);
    checkOutput("pair_data", dstrm_data, {DATA_B, DATA_A});
    checkOutput("pair_protid", {124'h0, dstrm_protid}, 128'h9);
    checkOutput("pair_dvalid", {126'h0, dstrm_dvalid}, 128'h3);
    checkOutput("pair_crc", {120'h0, dstrm_crc}, 128'h43);
    checkOutput("pair_crcv", {126'h0, dstrm_crc_valid}, 128'h3);
    checkOutput("nopair_b_valid", {126'h0, d0Valid}, 128'h1);
    checkOutput("nopair_b_data", d0Data, {64'h0, DATA_B});
    tick();
    checkOutput("pair_one_cycle", {126'h0, dstrm_valid}, 128'h0);
    checkOutput("pair_idle_data", dstrm_data, 128'h0);
    checkStatus("pair_status");
    checkOutput("nopair_status", {96'h0, d0Status}, 128'h0);
    tick();

    $display("[TB] timeout");
    applyStimulus(1'b1, DATA_A, 2'd1, 1'b1, 4'h3, 1'b1);
    tick();
    idle();
    cnt = 1;
    while (dstrm_valid == 2'b00 && cnt < 20) begin
      tick();
      cnt++;
    end
    flushExp++;
    checkOutput("timeout_latency", 128'(cnt), 128'd9);
    checkOutput("timeout_valid", {126'h0, dstrm_valid}, 128'h1);
    checkOutput("timeout_data", dstrm_data, {64'h0, DATA_A});
    checkOutput("timeout_protid", {124'h0, dstrm_protid}, 128'h1);
    tick();
    checkOutput("timeout_one_cycle", {126'h0, dstrm_valid}, 128'h0);
    checkStatus("timeout_status");
    tick();

    $display("[TB] collision");
    applyStimulus(1'b1, DATA_A, 2'd1, 1'b1, 4'h3, 1'b1);
    tick();
    idle();
    seen = 2'b00;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen = seen | dstrm_valid;
    end
    checkOutput("collision_no_early", {126'h0, seen}, 128'h0);
    applyStimulus(1'b1, DATA_B, 2'd2, 1'b1, 4'h4, 1'b1);
    tick();
    idle();
    pairExp++;
    checkOutput("collision_valid", {126'h0, dstrm_valid}, 128'h3);
    checkOutput("collision_data", dstrm_data, {DATA_B, DATA_A});
    tick();
    checkOutput("collision_after", {126'h0, dstrm_valid}, 128'h0);
    checkStatus("collision_status");
    tick();

    $display("[TB] link drop");
    applyStimulus(1'b1, DATA_A, 2'd1, 1'b1, 4'h3, 1'b1);
    tick();
    link_online = 1'b0;
    applyStimulus(1'b1, DATA_B, 2'd2, 1'b1, 4'h4, 1'b1);
    #1;
    checkOutput("drop_ready", {127'h0, in_ready}, 128'h0);
    tick();
    idle();
    flushExp++;
    checkOutput("drop_valid", {126'h0, dstrm_valid}, 128'h1);
    checkOutput("drop_data", dstrm_data, {64'h0, DATA_A});
    tick();
    checkOutput("drop_after", {126'h0, dstrm_valid}, 128'h0);
    checkStatus("drop_status");
    link_online = 1'b1;
    tick();

    $display("[TB] field gating");
    applyStimulus(1'b1, DATA_X, 2'd3, 1'b0, 4'hA, 1'b1);
    tick();
    applyStimulus(1'b1, DATA_Y, 2'd0, 1'b1, 4'h5, 1'b0);
    tick();
    idle();
    pairExp++;
    checkOutput("gate_valid", {126'h0, dstrm_valid}, 128'h3);
    checkOutput("gate_dvalid", {126'h0, dstrm_dvalid}, 128'h2);
    checkOutput("gate_crc", {120'h0, dstrm_crc}, 128'h5A);
    checkOutput("gate_crcv", {126'h0, dstrm_crc_valid}, 128'h1);
    checkOutput("gate_protid", {124'h0, dstrm_protid}, 128'h3);
    tick();
    checkStatus("gate_status");

    $display("[TB] state passthrough");
    in_state = 4'h3;
    tick();
    checkOutput("state_a", {120'h0, dstrm_state}, 128'h33);
    in_state = 4'hC;
    tick();
    checkOutput("state_b", {120'h0, dstrm_state}, 128'hCC);

    $display("[TB] reset in HALF");
    applyStimulus(1'b1, DATA_A, 2'd1, 1'b1, 4'h3, 1'b1);
    tick();
    idle();
    rst_wr = 1'b1;
    #1;
    pairExp  = 0;
    flushExp = 0;
    checkOutput("rst_async_state", {120'h0, dstrm_state}, 128'h0);
    checkStatus("rst_async_status");
    tick();
    rst_wr = 1'b0;
    seen = 2'b00;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | dstrm_valid;
    end
    checkOutput("rst_no_emit", {126'h0, seen}, 128'h0);
    checkStatus("rst_status");

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
